// File: rtl/latch_cap_pkg.sv
// Shared constants and helpers for the latch change-capture block.
//   DEF_WIDTH / DEF_DEPTH / DEF_CNT_W : default parameter values
//   ptr_w()   : FIFO pointer width (one extra wrap bit over the address)
//   sat_max() : all-ones value of the drop counter for a given width
//   sat_inc() : saturating increment used by the drop counter
package latch_cap_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_CNT_W = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Counter widths above 32 are not supported by these helpers.
  function automatic logic [31:0] sat_max(input int cnt_w);
    if (cnt_w >= 32) return '1;
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int cnt_w);
    if (v >= sat_max(cnt_w)) return v;
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/latch_cap_fifo.sv
// First-word-fall-through FIFO for captured latch words.
//   clk, rst   : clock, synchronous active-high reset
//   push       : request to store wr_data
//   wr_data    : word to store
//   accept     : push was taken this cycle (not full, or full with a pop)
//   ready      : consumer takes the head this cycle
//   valid      : head holds a word
//   head       : head word, 0 when empty
//   fill       : occupancy 0..DEPTH
module latch_cap_fifo
  import latch_cap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     accept,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [ptr_w(DEPTH)-1:0]  fill
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;

  // The extra MSB distinguishes full from empty when the address bits match.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid  = !empty;
  assign pop    = valid && ready;
  // When full, a simultaneous pop frees the slot being written; the head is
  // read combinationally before the edge, so overwriting it is safe.
  assign accept = push && (!full || pop);
  assign head   = valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign fill   = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/latch_change_capture.sv
// Samples the latch stage output into the clk domain, queues each new value
// seen while the latch is enabled, and exposes the queue as valid/ready.
//   clk, rst   : clock, synchronous active-high reset
//   lat_en     : enable of the upstream latch stage
//   lat_data   : latch output word
//   out_valid  : head word available
//   out_ready  : consumer takes the head this cycle
//   out_data   : head word, 0 when empty
//   fill       : FIFO occupancy 0..DEPTH
//   drop_cnt   : words lost to a full FIFO, saturating
//   overflow   : sticky, set on the first drop
module latch_change_capture
  import latch_cap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lat_en,
  input  logic [WIDTH-1:0]         lat_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [ptr_w(DEPTH)-1:0]  fill,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  logic             s_en;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] last_val;
  logic             has_last;
  logic             push;
  logic             accept;
  logic             drop;
  logic [31:0]      drop_ext;

  // Single sample register: the latch output is treated as quasi-static.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_en   <= 1'b0;
      s_data <= '0;
    end else begin
      s_en   <= lat_en;
      s_data <= lat_data;
    end
  end

  // has_last is cleared while disabled so the first sample after the enable
  // returns is always queued, even if it matches the old value.
  assign push = s_en && (!has_last || (s_data != last_val));

  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= '0;
      has_last <= 1'b0;
    end else if (!s_en) begin
      has_last <= 1'b0;
    end else if (push) begin
      last_val <= s_data;
      has_last <= 1'b1;
    end
  end

  assign drop     = push && !accept;
  assign drop_ext = 32'(drop_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      drop_cnt <= CNT_W'(sat_inc(drop_ext, CNT_W));
      overflow <= 1'b1;
    end
  end

  latch_cap_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (s_data),
    .accept  (accept),
    .ready   (out_ready),
    .valid   (out_valid),
    .head    (out_data),
    .fill    (fill)
  );

endmodule

// File: tb/tb_latch_change_capture.sv
module tb_latch_change_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        lat_en;
  logic [31:0] lat_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  fill;
  logic [7:0]  drop_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  latch_change_capture dut (
    .clk       (clk),
    .rst       (rst),
    .lat_en    (lat_en),
    .lat_data  (lat_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .drop_cnt  (drop_cnt),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ef;
    logic [7:0]  edrop;
    logic        eovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [31:0] d, logic rd,
                              logic v, logic [31:0] xd, logic [2:0] f,
                              logic [7:0] dc, logic o);
    vec_t t;
    t.rst = r; t.en = e; t.data = d; t.rdy = rd;
    t.ev = v; t.ed = xd; t.ef = f; t.edrop = dc; t.eovf = o;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [31:0] d,
                         input logic [2:0] f, input logic [7:0] dc, input logic o);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, " out_data"},  out_data, d);
    chk({tag, " fill"},      32'(fill), 32'(f));
    chk({tag, " drop_cnt"},  32'(drop_cnt), 32'(dc));
    chk({tag, " overflow"},  32'(overflow), 32'(o));
  endtask

  initial begin
    rst = 1'b1; lat_en = 1'b1; lat_data = '0; out_ready = 1'b0;

    // Reset held three cycles with random data on the latch.
    for (int i = 0; i < 3; i++) begin
      lat_data = $urandom;
      step();
      chk_all($sformatf("reset%0d", i), 1'b0, 32'h0, 3'd0, 8'd0, 1'b0);
    end

    // release
    vecs.push_back(mk(0,0,32'h00,0, 0,32'h00,0,0,0));
    // single held value: one word, visible two edges after stimulus
    vecs.push_back(mk(0,1,32'hA5,1, 0,32'h00,0,0,0));
    vecs.push_back(mk(0,1,32'hA5,1, 1,32'hA5,1,0,0));
    vecs.push_back(mk(0,1,32'hA5,1, 0,32'h00,0,0,0));
    vecs.push_back(mk(0,1,32'hA5,1, 0,32'h00,0,0,0));
    // fill past capacity with the consumer stalled, then drain
    vecs.push_back(mk(0,1,32'd1,0, 0,32'd0,0,0,0));
    vecs.push_back(mk(0,1,32'd2,0, 1,32'd1,1,0,0));
    vecs.push_back(mk(0,1,32'd3,0, 1,32'd1,2,0,0));
    vecs.push_back(mk(0,1,32'd4,0, 1,32'd1,3,0,0));
    vecs.push_back(mk(0,1,32'd5,0, 1,32'd1,4,0,0));
    vecs.push_back(mk(0,1,32'd6,0, 1,32'd1,4,1,1));
    vecs.push_back(mk(0,1,32'd6,0, 1,32'd1,4,2,1));
    vecs.push_back(mk(0,1,32'd6,0, 1,32'd1,4,2,1));
    vecs.push_back(mk(0,1,32'd6,1, 1,32'd2,3,2,1));
    vecs.push_back(mk(0,1,32'd6,1, 1,32'd3,2,2,1));
    vecs.push_back(mk(0,1,32'd6,1, 1,32'd4,1,2,1));
    vecs.push_back(mk(0,1,32'd6,1, 0,32'd0,0,2,1));
    // full FIFO with simultaneous push and pop: no drops, order kept
    vecs.push_back(mk(0,1,32'd7,0,  0,32'd0,0,2,1));
    vecs.push_back(mk(0,1,32'd8,0,  1,32'd7,1,2,1));
    vecs.push_back(mk(0,1,32'd9,0,  1,32'd7,2,2,1));
    vecs.push_back(mk(0,1,32'd10,0, 1,32'd7,3,2,1));
    vecs.push_back(mk(0,1,32'd11,0, 1,32'd7,4,2,1));
    vecs.push_back(mk(0,1,32'd12,1, 1,32'd8,4,2,1));
    vecs.push_back(mk(0,1,32'd13,1, 1,32'd9,4,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 1,32'd10,4,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 1,32'd11,4,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 1,32'd12,3,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 1,32'd13,2,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 1,32'd14,1,2,1));
    vecs.push_back(mk(0,1,32'd14,1, 0,32'd0,0,2,1));
    // enable dropped for one cycle: same value queued twice
    vecs.push_back(mk(0,1,32'h10,0, 0,32'h00,0,2,1));
    vecs.push_back(mk(0,0,32'h10,0, 1,32'h10,1,2,1));
    vecs.push_back(mk(0,1,32'h10,0, 1,32'h10,1,2,1));
    vecs.push_back(mk(0,1,32'h10,0, 1,32'h10,2,2,1));
    vecs.push_back(mk(0,1,32'h10,0, 1,32'h10,2,2,1));
    vecs.push_back(mk(0,1,32'h10,1, 1,32'h10,1,2,1));
    vecs.push_back(mk(0,1,32'h10,1, 0,32'h00,0,2,1));
    // reach fill=3, drop_cnt=5, then reset mid-stream
    vecs.push_back(mk(0,1,32'd32,0, 0,32'd0,0,2,1));
    vecs.push_back(mk(0,1,32'd33,0, 1,32'd32,1,2,1));
    vecs.push_back(mk(0,1,32'd34,0, 1,32'd32,2,2,1));
    vecs.push_back(mk(0,1,32'd35,0, 1,32'd32,3,2,1));
    vecs.push_back(mk(0,1,32'd36,0, 1,32'd32,4,2,1));
    vecs.push_back(mk(0,1,32'd37,0, 1,32'd32,4,3,1));
    vecs.push_back(mk(0,1,32'd38,0, 1,32'd32,4,4,1));
    vecs.push_back(mk(0,1,32'd39,0, 1,32'd32,4,5,1));
    vecs.push_back(mk(0,1,32'd39,1, 1,32'd33,4,5,1));
    vecs.push_back(mk(0,1,32'd39,1, 1,32'd34,3,5,1));
    vecs.push_back(mk(0,1,32'd39,0, 1,32'd34,3,5,1));
    vecs.push_back(mk(1,1,32'd39,1, 0,32'd0,0,0,0));
    vecs.push_back(mk(0,0,32'd39,1, 0,32'd0,0,0,0));
    vecs.push_back(mk(0,1,32'd39,0, 0,32'd0,0,0,0));
    vecs.push_back(mk(0,1,32'd39,0, 1,32'd39,1,0,0));
    vecs.push_back(mk(0,1,32'd39,1, 0,32'd0,0,0,0));

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      lat_en    = vecs[i].en;
      lat_data  = vecs[i].data;
      out_ready = vecs[i].rdy;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ef,
              vecs[i].edrop, vecs[i].eovf);
    end

    // Drop counter saturation: a new value every cycle into a stalled FIFO.
    // The first edge sees the previous value 39 (no push); 269 pushes follow,
    // 4 stored and 265 dropped, so the counter must sit at 255.
    rst = 1'b0; lat_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 270; i++) begin
      lat_data = (i % 2 == 0) ? 32'd100 : 32'd101;
      step();
    end
    chk("sat drop_cnt", 32'(drop_cnt), 32'd255);
    chk("sat overflow", 32'(overflow), 32'd1);
    chk("sat fill",     32'(fill), 32'd4);
    chk("sat head",     out_data, 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
